mips_ctrl_pipe: RTL and testbench

Pipelined control tracker and hazard unit for the 5-stage MIPS core; sits downstream of the main opcode decoder. It consumes the decoded control bundle in ID and carries it through ID/EX, EX/MEM and MEM/WB. It also detects load-use and control hazards and drives the PC and IF/ID write-enables, the flush signals and the EX-stage forwarding selects.

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/mips_ctrl_pipe_if.sv | 38 +++
 rtl/mips_fwd_unit.sv | 25 ++
 rtl/mips_ctrl_pipe.sv | 103 ++++++++++
 tb/tb_mips_ctrl_pipe.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control-bundle definitions for the MIPS pipeline control tracker.
// Field order of ctrl_t fixes the bit positions of the 10-bit decoder bundle.
package mips_ctrl_pkg;

  localparam int CTRL_W = 10;

  // MSB first: {RegDst, Branch, MemRead, MemtoReg, ALUop[1:0], MemWrite, ALUsrc, RegWrite, Jump}
  typedef struct packed {
    logic       regDst;
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic [1:0] aluOp;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic       jump;
  } ctrl_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mips_ctrl_pipe_if.sv
// Bus between the ID-stage decoder/datapath and the control tracker.
// The decoder side is the master; the tracker is the slave.
interface mips_ctrl_pipe_if
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W = 5
);
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              ex_zero;
  logic              pc_write;
  logic              ifid_write;
  logic              flush_ifid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [REG_W-1:0]  ex_dst;
  logic [REG_W-1:0]  mem_dst;
  logic [REG_W-1:0]  wb_dst;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              branch_taken;

  modport master (
    output id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    input  pc_write, ifid_write, flush_ifid, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_dst, mem_dst, wb_dst, fwd_a, fwd_b, branch_taken
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    output pc_write, ifid_write, flush_ifid, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_dst, mem_dst, wb_dst, fwd_a, fwd_b, branch_taken
  );
endinterface

// File: rtl/mips_fwd_unit.sv
// Combinational forwarding select for one EX source operand.
// EX/MEM has priority over MEM/WB; register 0 is never forwarded.
module mips_fwd_unit
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] srcReg,
  input  logic             memRegWrite,
  input  logic [REG_W-1:0] memDst,
  input  logic             wbRegWrite,
  input  logic [REG_W-1:0] wbDst,
  output logic [1:0]       fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (memRegWrite && (memDst != '0) && (memDst == srcReg)) begin
      fwdSel = FWD_MEM;
    end else if (wbRegWrite && (wbDst != '0) && (wbDst == srcReg)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Pipelined control tracker and hazard unit: carries the decoded bundle
// ID->EX->MEM->WB and resolves load-use, branch and jump hazards.
module mips_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  mips_ctrl_pipe_if.slave bus
);

  ctrl_t            idCtrl;
  logic [REG_W-1:0] idDst;
  ctrl_t            exCtrl_p0;
  logic [REG_W-1:0] exDst_p0;
  logic [REG_W-1:0] exRs_p0;
  logic [REG_W-1:0] exRt_p0;
  ctrl_t            memCtrl_p1;
  logic [REG_W-1:0] memDst_p1;
  ctrl_t            wbCtrl_p2;
  logic [REG_W-1:0] wbDst_p2;
  logic             branchTaken;
  logic             loadUse;
  logic             stall;
  logic             squash;

  assign idCtrl = bus.id_valid ? ctrl_t'(bus.id_ctrl) : CTRL_BUBBLE;
  assign idDst  = idCtrl.regDst ? bus.id_rd : bus.id_rt;

  // MemRead alone is not a load: the decoder raises it for some immediate ALU ops.
  assign branchTaken = exCtrl_p0.branch & bus.ex_zero;
  assign loadUse = exCtrl_p0.memRead & exCtrl_p0.memToReg & (exDst_p0 != '0) &
                   ((exDst_p0 == bus.id_rs) | (exDst_p0 == bus.id_rt));
  assign stall  = loadUse & ~branchTaken;
  assign squash = branchTaken | stall;

  assign bus.pc_write     = ~stall;
  assign bus.ifid_write   = ~stall;
  assign bus.flush_ifid   = branchTaken | (idCtrl.jump & ~stall);
  assign bus.branch_taken = branchTaken;

  // ID -> ID/EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exCtrl_p0 <= CTRL_BUBBLE;
      exDst_p0  <= '0;
      exRs_p0   <= '0;
      exRt_p0   <= '0;
    end else if (squash) begin
      exCtrl_p0 <= CTRL_BUBBLE;
      exDst_p0  <= '0;
      exRs_p0   <= '0;
      exRt_p0   <= '0;
    end else begin
      exCtrl_p0 <= idCtrl;
      exDst_p0  <= idDst;
      exRs_p0   <= bus.id_rs;
      exRt_p0   <= bus.id_rt;
    end
  end

  // ID/EX -> EX/MEM -> MEM/WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memCtrl_p1 <= CTRL_BUBBLE;
      memDst_p1  <= '0;
      wbCtrl_p2  <= CTRL_BUBBLE;
      wbDst_p2   <= '0;
    end else begin
      memCtrl_p1 <= exCtrl_p0;
      memDst_p1  <= exDst_p0;
      wbCtrl_p2  <= memCtrl_p1;
      wbDst_p2   <= memDst_p1;
    end
  end

  assign bus.ex_ctrl  = exCtrl_p0;
  assign bus.mem_ctrl = memCtrl_p1;
  assign bus.wb_ctrl  = wbCtrl_p2;
  assign bus.ex_dst   = exDst_p0;
  assign bus.mem_dst  = memDst_p1;
  assign bus.wb_dst   = wbDst_p2;

  mips_fwd_unit #(.REG_W(REG_W)) uFwdA (
    .srcReg      (exRs_p0),
    .memRegWrite (memCtrl_p1.regWrite),
    .memDst      (memDst_p1),
    .wbRegWrite  (wbCtrl_p2.regWrite),
    .wbDst       (wbDst_p2),
    .fwdSel      (bus.fwd_a)
  );

  mips_fwd_unit #(.REG_W(REG_W)) uFwdB (
    .srcReg      (exRt_p0),
    .memRegWrite (memCtrl_p1.regWrite),
    .memDst      (memDst_p1),
    .wbRegWrite  (wbCtrl_p2.regWrite),
    .wbDst       (wbDst_p2),
    .fwdSel      (bus.fwd_b)
  );

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Directed bench for mips_ctrl_pipe: hazards, forwarding, latency and reset.
module tb_mips_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   passCnt = 0;
  int   totalCnt = 0;

  // {RegDst, Branch, MemRead, MemtoReg, ALUop[1:0], MemWrite, ALUsrc, RegWrite, Jump}
  localparam logic [9:0] C_LW   = 10'b0_0_1_1_00_0_1_1_0;
  localparam logic [9:0] C_ADD  = 10'b1_0_0_0_10_0_0_1_0;
  localparam logic [9:0] C_ADDI = 10'b0_0_1_0_00_0_1_1_0;
  localparam logic [9:0] C_BEQ  = 10'b0_1_0_0_01_0_0_0_0;
  localparam logic [9:0] C_J    = 10'b0_0_0_0_00_0_0_0_1;

  mips_ctrl_pipe_if #(.REG_W(5)) bus ();

  mips_ctrl_pipe #(.REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic z);
    bus.id_valid = v;
    bus.id_ctrl  = c;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = rd;
    bus.ex_zero  = z;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
    chk("rst_mem_ctrl", 32'(bus.mem_ctrl), 32'h0);
    chk("rst_wb_ctrl", 32'(bus.wb_ctrl), 32'h0);
    chk("rst_pc_write", 32'(bus.pc_write), 32'h1);
    chk("rst_ifid_write", 32'(bus.ifid_write), 32'h1);
    chk("rst_flush", 32'(bus.flush_ifid), 32'h0);
    chk("rst_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'h0);
    chk("rst_branch", 32'(bus.branch_taken), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Load-use: lw $8, then add $3,$8,$2
    drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    chk("lw_no_stall", 32'(bus.pc_write), 32'h1);
    step();
    chk("lw_ex_ctrl", 32'(bus.ex_ctrl), 32'(C_LW));
    chk("lw_ex_dst", 32'(bus.ex_dst), 32'd8);
    drive(1'b1, C_ADD, 5'd8, 5'd2, 5'd3, 1'b0);
    chk("lu_pc_write", 32'(bus.pc_write), 32'h0);
    chk("lu_ifid_write", 32'(bus.ifid_write), 32'h0);
    chk("lu_flush", 32'(bus.flush_ifid), 32'h0);
    step();
    chk("lu_bubble", 32'(bus.ex_ctrl), 32'h0);
    chk("lu_bubble_dst", 32'(bus.ex_dst), 32'h0);
    chk("lu_mem_ctrl", 32'(bus.mem_ctrl), 32'(C_LW));
    chk("lu_one_cycle", 32'(bus.pc_write), 32'h1);
    step();
    chk("lu_add_ex", 32'(bus.ex_ctrl), 32'(C_ADD));
    chk("lu_add_dst", 32'(bus.ex_dst), 32'd3);
    chk("lu_wb_ctrl", 32'(bus.wb_ctrl), 32'(C_LW));
    chk("lu_fwd_a", 32'(bus.fwd_a), 32'b01);
    chk("lu_fwd_b", 32'(bus.fwd_b), 32'b00);

    // addi $9 (MemRead without MemtoReg) then add $10,$4,$9
    drive(1'b1, C_ADDI, 5'd0, 5'd9, 5'd0, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd4, 5'd9, 5'd10, 1'b0);
    chk("addi_no_stall", 32'(bus.pc_write), 32'h1);
    step();
    chk("addi_fwd_b", 32'(bus.fwd_b), 32'b10);
    chk("addi_fwd_a", 32'(bus.fwd_a), 32'b00);

    // Double match on $5, then RegWrite to $0
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd5, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd5, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 1'b0);
    step();
    chk("dbl_fwd_a", 32'(bus.fwd_a), 32'b10);
    chk("dbl_fwd_b", 32'(bus.fwd_b), 32'b00);
    drive(1'b1, C_ADD, 5'd1, 5'd1, 5'd0, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd7, 1'b0);
    step();
    chk("r0_fwd_a", 32'(bus.fwd_a), 32'b00);
    chk("r0_fwd_b", 32'(bus.fwd_b), 32'b00);

    // Load into $0 never stalls
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd11, 1'b0);
    chk("lw_r0_no_stall", 32'(bus.pc_write), 32'h1);
    step();

    // Taken branch
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd3, 5'd4, 5'd12, 1'b1);
    chk("bt_taken", 32'(bus.branch_taken), 32'h1);
    chk("bt_flush", 32'(bus.flush_ifid), 32'h1);
    chk("bt_pc_write", 32'(bus.pc_write), 32'h1);
    step();
    chk("bt_bubble", 32'(bus.ex_ctrl), 32'h0);

    // Not-taken branch
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd3, 5'd4, 5'd12, 1'b0);
    chk("bnt_taken", 32'(bus.branch_taken), 32'h0);
    chk("bnt_flush", 32'(bus.flush_ifid), 32'h0);
    step();
    chk("bnt_ex_ctrl", 32'(bus.ex_ctrl), 32'(C_ADD));

    // Jump in ID
    drive(1'b1, C_J, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("j_flush", 32'(bus.flush_ifid), 32'h1);
    chk("j_pc_write", 32'(bus.pc_write), 32'h1);
    step();
    chk("j_ex_ctrl", 32'(bus.ex_ctrl), 32'(C_J));

    // Jump squashed by taken branch in EX
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    step();
    drive(1'b1, C_J, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("jb_flush", 32'(bus.flush_ifid), 32'h1);
    step();
    chk("jb_bubble", 32'(bus.ex_ctrl), 32'h0);

    // Branch in EX beats load-use with a load in ID
    drive(1'b1, C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    step();
    drive(1'b1, C_LW, 5'd2, 5'd13, 5'd0, 1'b1);
    chk("bl_pc_write", 32'(bus.pc_write), 32'h1);
    step();
    chk("bl_bubble", 32'(bus.ex_ctrl), 32'h0);

    // Stalled jump: no flush until it leaves ID
    drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    step();
    drive(1'b1, C_J, 5'd8, 5'd0, 5'd0, 1'b0);
    chk("sj_stall", 32'(bus.pc_write), 32'h0);
    chk("sj_no_flush", 32'(bus.flush_ifid), 32'h0);
    step();
    chk("sj_flush", 32'(bus.flush_ifid), 32'h1);
    step();
    chk("sj_ex_ctrl", 32'(bus.ex_ctrl), 32'(C_J));

    // Invalid ID slot enters as a bubble
    drive(1'b0, C_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    step();
    chk("inv_bubble", 32'(bus.ex_ctrl), 32'h0);

    // Asynchronous reset during a stall
    drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    step();
    drive(1'b1, C_ADD, 5'd8, 5'd2, 5'd3, 1'b0);
    chk("ar_stall", 32'(bus.pc_write), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pc_write", 32'(bus.pc_write), 32'h1);
    chk("ar_ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
    chk("ar_mem_ctrl", 32'(bus.mem_ctrl), 32'h0);
    chk("ar_wb_ctrl", 32'(bus.wb_ctrl), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_first_cycle", 32'(bus.ex_ctrl), 32'(C_ADD));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
